jtframe_dwnld_pack: RTL

//  Sits directly downstream of data_io during ROM download. Packs the 8-bit ioctl byte stream into
//  16-bit masked word writes and queues them in a small FIFO. Drains the queue to the SDRAM

---
 rtl/jtframe_dwnld_pkg.sv | 29 ++
 rtl/jtframe_dwnld_fifo.sv | 66 ++++++
 rtl/jtframe_dwnld_pack.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/jtframe_dwnld_pkg.sv
// Shared types and constants for the ROM-download byte packer.
package jtframe_dwnld_pkg;

  // Widest word address a 25-bit byte bus can produce; the top uses the low AW bits.
  localparam int ADDR_W = 24;

  // Active-low byte enables {hi,lo}, DQM polarity.
  localparam logic [1:0] MASK_WORD = 2'b00;
  localparam logic [1:0] MASK_LO   = 2'b10;
  localparam logic [1:0] MASK_HI   = 2'b01;

  typedef enum logic {IDLE, WRITE} drain_st_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic [1:0]        mask;
  } dwnld_word_t;

  // Swap byte lanes and their enables together so a word stays self-consistent.
  function automatic dwnld_word_t lane_swap(input dwnld_word_t w);
    dwnld_word_t s;
    s      = w;
    s.data = {w.data[7:0], w.data[15:8]};
    s.mask = {w.mask[0], w.mask[1]};
    return s;
  endfunction

endpackage

// File: rtl/jtframe_dwnld_fifo.sv
// Small synchronous FIFO of packed download words. Exposes the head and the
// entry behind it so the drain can issue back-to-back writes.
module jtframe_dwnld_fifo
  import jtframe_dwnld_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  dwnld_word_t wr_data,
  input  logic        pop,
  output dwnld_word_t head,
  output dwnld_word_t next,
  output logic        empty,
  output logic        full,
  output logic        more
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dwnld_word_t   mem [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (PW+1)'(DEPTH));
  assign more  = (count_q >= (PW+1)'(2));
  assign head  = mem[rptr_q];
  assign next  = mem[rptr_q + 1'b1];

  // A push on full is accepted only when a pop frees the slot in the same cycle.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array, data only.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wr_data;
  end

endmodule

// File: rtl/jtframe_dwnld_pack.sv
// Packs the data_io byte stream into 16-bit masked SDRAM word writes, queues
// them and drains them through the prog_* we/rdy handshake.
// Optional feature macro: JTFRAME_DWNLD_CHKSUM_EN adds a 16-bit byte checksum.
// data_io strobes ioctl_wr at most every other cycle; the second word of a
// split odd-byte event is issued in the gap.
module jtframe_dwnld_pack
  import jtframe_dwnld_pkg::*;
#(
  parameter int AW    = 22,
  parameter int DEPTH = 4,
  parameter int SWAB  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          downloading,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_data,
  input  logic          ioctl_wr,
  output logic [AW-1:0] prog_addr,
  output logic [15:0]   prog_data,
  output logic [1:0]    prog_mask,
  output logic          prog_we,
  input  logic          prog_rdy,
  output logic          dwnld_busy,
  output logic          overflow,
  output logic          addr_err
`ifdef JTFRAME_DWNLD_CHKSUM_EN
  ,
  output logic [15:0]   checksum
`endif
);

  // Control state
  logic        dl_q;
  logic        pend_vld_q, pend_vld_d;
  logic        hold_vld_q, hold_vld_d;
  logic        overflow_q, overflow_d;
  logic        addr_err_q, addr_err_d;
  // Data state
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]    pend_byte_q, pend_byte_d;
  dwnld_word_t   hold_word_q, hold_word_d;
  // Drain outputs
  drain_st_e     st_q;
  logic [AW-1:0] prog_addr_q;
  logic [15:0]   prog_data_q;
  logic [1:0]    prog_mask_q;
  logic          prog_we_q;

  logic [AW-1:0] byte_waddr;
  logic          byte_odd, range_err, byte_ok, dl_rise, dl_fall;
  logic          push;
  dwnld_word_t   push_word, flush_word, pair_word, odd_word;
  dwnld_word_t   fifo_head, fifo_next;
  logic          fifo_empty, fifo_full, fifo_more, fifo_pop;
  logic          unused_addr_hi;

  function automatic dwnld_word_t mk_word(input logic [AW-1:0] a, input logic [15:0] d,
                                          input logic [1:0] m);
    dwnld_word_t w;
    w.addr = ADDR_W'(a);
    w.data = d;
    w.mask = m;
    return (SWAB != 0) ? lane_swap(w) : w;
  endfunction

  // Upper FIFO address bits are always zero since out-of-range bytes are discarded.
  assign unused_addr_hi = ^{fifo_head.addr, fifo_next.addr};

  // Byte classification and the word the packer hands to the FIFO this cycle.
  always_comb begin
    byte_waddr = ioctl_addr[AW:1];
    byte_odd   = ioctl_addr[0];
    range_err  = (ioctl_addr >> (AW+1)) != '0;
    byte_ok    = downloading && ioctl_wr && !range_err;
    dl_rise    = downloading && !dl_q;
    dl_fall    = !downloading && dl_q;
    flush_word = mk_word(pend_addr_q, {8'h00, pend_byte_q}, MASK_LO);
    pair_word  = mk_word(byte_waddr, {ioctl_data, pend_byte_q}, MASK_WORD);
    odd_word   = mk_word(byte_waddr, {ioctl_data, 8'h00}, MASK_HI);

    push        = 1'b0;
    push_word   = flush_word;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    pend_byte_d = pend_byte_q;
    hold_vld_d  = hold_vld_q;
    hold_word_d = hold_word_q;

    if (hold_vld_q) begin
      push       = 1'b1;
      push_word  = hold_word_q;
      hold_vld_d = 1'b0;
    end else if (byte_ok) begin
      if (!byte_odd) begin
        push        = pend_vld_q;
        pend_vld_d  = 1'b1;
        pend_addr_d = byte_waddr;
        pend_byte_d = ioctl_data;
      end else if (pend_vld_q && pend_addr_q == byte_waddr) begin
        push       = 1'b1;
        push_word  = pair_word;
        pend_vld_d = 1'b0;
      end else if (pend_vld_q) begin
        push        = 1'b1;
        pend_vld_d  = 1'b0;
        hold_vld_d  = 1'b1;
        hold_word_d = odd_word;
      end else begin
        push      = 1'b1;
        push_word = odd_word;
      end
    end else if (dl_fall && pend_vld_q) begin
      push       = 1'b1;
      pend_vld_d = 1'b0;
    end

    overflow_d = dl_rise ? 1'b0 : (overflow_q || (push && fifo_full && !fifo_pop));
    addr_err_d = dl_rise ? 1'b0 : (addr_err_q || (downloading && ioctl_wr && range_err));
  end

  // Packer and sticky-flag control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dl_q       <= 1'b0;
      pend_vld_q <= 1'b0;
      hold_vld_q <= 1'b0;
      overflow_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      dl_q       <= downloading;
      pend_vld_q <= pend_vld_d;
      hold_vld_q <= hold_vld_d;
      overflow_q <= overflow_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Packer data registers, qualified by the valid flags above.
  always_ff @(posedge clk) begin
    pend_addr_q <= pend_addr_d;
    pend_byte_q <= pend_byte_d;
    hold_word_q <= hold_word_d;
  end

  assign fifo_pop = (st_q == WRITE) && prog_rdy;

  jtframe_dwnld_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (push_word),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .next    (fifo_next),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .more    (fifo_more)
  );

  // Drain FSM: the in-flight word stays at the FIFO head until prog_rdy pops it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      prog_we_q   <= 1'b0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      prog_mask_q <= 2'b11;
    end else begin
      case (st_q)
        IDLE: begin
          if (!fifo_empty) begin
            prog_addr_q <= fifo_head.addr[AW-1:0];
            prog_data_q <= fifo_head.data;
            prog_mask_q <= fifo_head.mask;
            prog_we_q   <= 1'b1;
            st_q        <= WRITE;
          end
        end
        WRITE: begin
          if (prog_rdy) begin
            if (fifo_more) begin
              prog_addr_q <= fifo_next.addr[AW-1:0];
              prog_data_q <= fifo_next.data;
              prog_mask_q <= fifo_next.mask;
            end else begin
              prog_we_q <= 1'b0;
              st_q      <= IDLE;
            end
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

`ifdef JTFRAME_DWNLD_CHKSUM_EN
  logic [15:0] chk_q, chk_d;

  // Wrapping sum of accepted bytes, restarted on each download.
  always_comb begin
    chk_d = (dl_rise ? 16'h0000 : chk_q) + (byte_ok ? {8'h00, ioctl_data} : 16'h0000);
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (!rst_n) chk_q <= 16'h0000;
    else        chk_q <= chk_d;
  end

  assign checksum = chk_q;
`endif

  assign prog_addr  = prog_addr_q;
  assign prog_data  = prog_data_q;
  assign prog_mask  = prog_mask_q;
  assign prog_we    = prog_we_q;
  assign overflow   = overflow_q;
  assign addr_err   = addr_err_q;
  assign dwnld_busy = downloading || pend_vld_q || hold_vld_q || !fifo_empty || prog_we_q;

endmodule
